mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum wait cycles per memory access (used only with MEM_ARB_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 pc  input  32  core fetch address.
REQ-005 Mem_read, Mem_write  input  1 each  core data-access strobes, decoded from instr.
REQ-006 a_data_mem, w_data_mem  input  32 each  core data address and write data.
REQ-007 instr  output  32  instruction register to core.
REQ-008 r_data_mem  output  32  data read register to core.
REQ-009 stall  output  1  freezes core PC and architectural state when 1.
REQ-010 mem_req, mem_we  output  1 each  shared single-port memory request and write enable.
REQ-011 mem_addr, mem_wdata  output  32 each  memory address and write data.
REQ-012 mem_ack  input  1  memory completion; may assert in the same cycle as mem_req.
REQ-013 mem_rdata  input  32  read data, valid while mem_ack=1.
REQ-014 bus_err  output  1  sticky access-timeout flag.

Function
REQ-015 FSM states FETCH, EXEC, COMMIT shall share the single memory port between instruction fetch and data access.
REQ-016 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on mem_ack, instr<=mem_rdata and go to EXEC; otherwise hold.
REQ-017 EXEC with Mem_read or Mem_write=1: mem_req=1, mem_addr=a_data_mem, mem_we=Mem_write, mem_wdata=w_data_mem; on mem_ack, r_data_mem<=mem_rdata (reads only) and go to COMMIT.
REQ-018 EXEC with Mem_read=Mem_write=0: mem_req=0; go to COMMIT next cycle.
REQ-019 COMMIT: stall=0 for exactly one cycle, mem_req=0; go to FETCH.
REQ-020 stall shall be 1 in FETCH and EXEC, 0 only in COMMIT.
REQ-021 With zero-wait memory (mem_ack same cycle), every instruction takes exactly 3 cycles.
REQ-022 mem_req, once asserted, shall stay high with stable mem_addr/mem_we/mem_wdata until mem_ack.
REQ-023 mem_ack while mem_req=0 shall be ignored and change no state.
REQ-024 Mem_read and Mem_write both 1 shall be treated as a write.
REQ-025 r_data_mem shall hold its value across write and non-memory instructions.
REQ-026 mem_we shall never be 1 while mem_req=0.

Reset
REQ-027 reset=0 shall immediately (asynchronously) force state FETCH, mem_req=0, mem_we=0, stall=1, instr=0, r_data_mem=0, bus_err=0, timeout counter=0.
REQ-028 Reset mid-access shall abandon the access; an mem_ack arriving during reset shall be ignored.
REQ-029 First request after reset release: fetch at current pc, mem_req=1 in first cycle after release.

Configuration
REQ-030 Macro MEM_ARB_TIMEOUT_EN defined: counter increments each cycle mem_req=1 without mem_ack, clears on every state change; on reaching TIMEOUT, access aborts, bus_err sets (sticky until reset), FETCH loads instr=32'h00000013 (NOP), data read loads r_data_mem=0, FSM goes to EXEC/COMMIT respectively.
REQ-031 Macro undefined: no counter; waits indefinitely for mem_ack; bus_err tied 0.

Verification
REQ-032 Zero-wait memory, pc=0, ADD instruction -> mem_req only in FETCH, stall pattern 1,1,0, 3 cycles/instruction.
REQ-033 LW, memory acks 2 cycles after each request -> fetch then read at a_data_mem, r_data_mem=mem_rdata, stall low 1 cycle after 7 total cycles.
REQ-034 SW addr 0x100 data 0xDEADBEEF -> mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF held until ack; r_data_mem unchanged.
REQ-035 reset asserted during EXEC of LW with mem_req high -> mem_req=0 same cycle, all outputs at reset values, fetch restarts after release.
REQ-036 MEM_ARB_TIMEOUT_EN, TIMEOUT=15, no mem_ack on fetch -> after 15 cycles instr=0x00000013, bus_err=1 and stays 1 over later instructions.
REQ-037 Spurious mem_ack during COMMIT -> no state, instr or r_data_mem change.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Shared single-port memory bus between the arbiter (master) and memory (slave).
// Latency: none, plain wires; the request is held until the memory acknowledges it.
// Backpressure: memory stalls the master by withholding mem_ack; it may ack in the request cycle.
interface mem_arbiter_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data access (FETCH/EXEC/COMMIT).
// Latency: 3 cycles per instruction with zero-wait memory, plus memory wait states.
// Backpressure: core held by stall until COMMIT; optional abort via MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
   parameter int TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 reset,        // asynchronous, active low
   input  logic [31:0]          pc,
   input  logic                 Mem_read,
   input  logic                 Mem_write,
   input  logic [31:0]          a_data_mem,
   input  logic [31:0]          w_data_mem,
   output logic [31:0]          instr,
   output logic [31:0]          r_data_mem,
   output logic                 stall,
   output logic                 bus_err,
   mem_arbiter_if.master        mem
);

   localparam logic [1:0] ST_FETCH  = 2'd0;
   localparam logic [1:0] ST_EXEC   = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;

   // Instruction substituted when a fetch is aborted (addi x0,x0,0).
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   logic [1:0]  r_state;
   logic [31:0] r_instr;
   logic [31:0] r_rdata;

   logic w_is_mem;
   logic w_rd_only;
   logic w_mem_req;
   logic w_ack;
   logic w_abort;

   // Request decode; reset gates the request so it drops the instant reset asserts.
   always_comb begin
      w_is_mem  = Mem_read | Mem_write;
      w_rd_only = Mem_read & ~Mem_write;   // read+write together is a write
      w_mem_req = reset & ((r_state == ST_FETCH) ||
                           ((r_state == ST_EXEC) && w_is_mem));
      w_ack     = mem.mem_ack & w_mem_req; // acks without a request are ignored
   end

   // Memory bus drive: address/data come from state and stalled core inputs, so they hold until ack.
   always_comb begin
      mem.mem_req   = w_mem_req;
      mem.mem_we    = w_mem_req & (r_state == ST_EXEC) & Mem_write;
      mem.mem_addr  = (r_state == ST_EXEC) ? a_data_mem : pc;
      mem.mem_wdata = (r_state == ST_EXEC) ? w_data_mem : 32'h0;
   end

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] r_tmo_cnt;
   logic          r_bus_err;

   // Abort at the end of the TIMEOUT-th cycle spent waiting for an ack.
   assign w_abort = w_mem_req & ~mem.mem_ack & (r_tmo_cnt == CW'(TIMEOUT - 1));
   assign bus_err = r_bus_err;

   // Wait counter: counts unacknowledged request cycles, clears whenever the state moves on.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tmo_cnt <= '0;
      end else if (!w_mem_req || w_ack || w_abort) begin
         r_tmo_cnt <= '0;
      end else begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end

   // Sticky error flag, only reset clears it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_bus_err <= 1'b0;
      end else if (w_abort) begin
         r_bus_err <= 1'b1;
      end
   end
`else
   logic w_unused_tmo;

   assign w_abort      = 1'b0;
   assign bus_err      = 1'b0;
   assign w_unused_tmo = (TIMEOUT == 0);
`endif

   // Main FSM: fetch, optional data access, one-cycle commit window for the core.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_FETCH;
         r_instr <= 32'h0;
         r_rdata <= 32'h0;
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (w_ack) begin
                  r_instr <= mem.mem_rdata;
                  r_state <= ST_EXEC;
               end else if (w_abort) begin
                  r_instr <= NOP_INSTR;
                  r_state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (!w_is_mem) begin
                  r_state <= ST_COMMIT;
               end else if (w_ack) begin
                  if (w_rd_only) begin
                     r_rdata <= mem.mem_rdata;
                  end
                  r_state <= ST_COMMIT;
               end else if (w_abort) begin
                  if (w_rd_only) begin
                     r_rdata <= 32'h0;
                  end
                  r_state <= ST_COMMIT;
               end
            end
            ST_COMMIT: begin
               r_state <= ST_FETCH;
            end
            default: begin
               r_state <= ST_FETCH;
            end
         endcase
      end
   end

   assign instr      = r_instr;
   assign r_data_mem = r_rdata;
   assign stall      = (r_state != ST_COMMIT);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: latency-programmable memory model plus scoreboard.
// Latency: per-instruction cycle counts and per-cycle bus values are checked.
// Backpressure: memory wait states set per instruction; spurious acks injected on demand.
module tb_mem_arbiter;

   logic        clk;
   logic        reset;
   logic [31:0] pc;
   logic        Mem_read;
   logic        Mem_write;
   logic [31:0] a_data_mem;
   logic [31:0] w_data_mem;
   logic [31:0] instr;
   logic [31:0] r_data_mem;
   logic        stall;
   logic        bus_err;

   mem_arbiter_if mif ();

   mem_arbiter #(.TIMEOUT(15)) dut (
      .clk        (clk),
      .reset      (reset),
      .pc         (pc),
      .Mem_read   (Mem_read),
      .Mem_write  (Mem_write),
      .a_data_mem (a_data_mem),
      .w_data_mem (w_data_mem),
      .instr      (instr),
      .r_data_mem (r_data_mem),
      .stall      (stall),
      .bus_err    (bus_err),
      .mem        (mif.master)
   );

   int vec;
   int errs;
   int lat;
   int wait_cnt;
   logic spur;
   logic [31:0] shadow_rdata;
   logic [31:0] last_waddr;
   logic [31:0] last_wdata;
   logic [31:0] q_instr[$];
   logic [31:0] q_rdata[$];

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return (a * 32'd2654435761) ^ 32'h0000_0033;
   endfunction

   // Memory model: acks after lat wait cycles of a continuous request.
   assign mif.mem_ack   = (mif.mem_req && (wait_cnt >= lat)) || spur;
   assign mif.mem_rdata = (mif.mem_req && !mif.mem_we) ? mem_val(mif.mem_addr) : 32'hBAD0_BAD0;

   always @(posedge clk) begin
      if (!mif.mem_req || mif.mem_ack) wait_cnt <= 0;
      else                             wait_cnt <= wait_cnt + 1;
      if (mif.mem_req && mif.mem_ack && mif.mem_we) begin
         last_waddr <= mif.mem_addr;
         last_wdata <= mif.mem_wdata;
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, got running, need finished");
      $fatal(1);
   end

   // Drives one instruction starting at a commit (or post-reset) point; checks every cycle.
   task automatic run_instr(input logic [31:0] t_pc, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wdata, input int t_lat);
      int   f;
      int   e;
      int   k;
      logic m;
      logic exp_req;
      logic exp_we;
      logic exp_stall;
      logic [31:0] exp_addr;
      logic [31:0] ei;
      logic [31:0] er;
      pc = t_pc; Mem_read = rd; Mem_write = wr; a_data_mem = addr; w_data_mem = wdata; lat = t_lat;
      m = rd | wr;
      f = t_lat + 1;
      e = m ? t_lat + 1 : 1;
      q_instr.push_back(mem_val(t_pc));
      if (rd && !wr) shadow_rdata = mem_val(addr);
      q_rdata.push_back(shadow_rdata);
      k = 0;
      do begin
         @(negedge clk);
         k++;
         exp_addr = t_pc;
         if (k <= f) begin
            exp_req = 1'b1; exp_we = 1'b0; exp_stall = 1'b1;
         end else if (k <= f + e) begin
            exp_req = m; exp_we = m & wr; exp_stall = 1'b1; exp_addr = addr;
         end else begin
            exp_req = 1'b0; exp_we = 1'b0; exp_stall = 1'b0;
         end
         vec++;
         if ({stall, mif.mem_req, mif.mem_we} !== {exp_stall, exp_req, exp_we}) begin
            errs++;
            $display("FAIL ctrl pc=%h cyc=%0d: got stall/req/we=%b%b%b need %b%b%b",
                     t_pc, k, stall, mif.mem_req, mif.mem_we, exp_stall, exp_req, exp_we);
         end
         if (exp_req) begin
            vec++;
            if (mif.mem_addr !== exp_addr) begin
               errs++;
               $display("FAIL addr pc=%h cyc=%0d: got %h need %h", t_pc, k, mif.mem_addr, exp_addr);
            end
         end
         if (exp_we) begin
            vec++;
            if (mif.mem_wdata !== wdata) begin
               errs++;
               $display("FAIL wdata pc=%h cyc=%0d: got %h need %h", t_pc, k, mif.mem_wdata, wdata);
            end
         end
      end while (stall !== 1'b0 && k < 64);
      vec++;
      if (k != f + e + 1) begin
         errs++;
         $display("FAIL cycles pc=%h: got %0d need %0d", t_pc, k, f + e + 1);
      end
      ei = q_instr.pop_front();
      er = q_rdata.pop_front();
      vec++;
      if (instr !== ei) begin
         errs++;
         $display("FAIL instr pc=%h: got %h need %h", t_pc, instr, ei);
      end
      vec++;
      if (r_data_mem !== er) begin
         errs++;
         $display("FAIL r_data_mem pc=%h: got %h need %h", t_pc, r_data_mem, er);
      end
   endtask

   task automatic test_reset;
      reset = 1'b0; pc = 32'h0; Mem_read = 1'b0; Mem_write = 1'b0;
      a_data_mem = 32'h0; w_data_mem = 32'h0; lat = 0; spur = 1'b1; shadow_rdata = 32'h0;
      repeat (3) @(negedge clk);
      vec++;
      if ({mif.mem_req, mif.mem_we, stall, bus_err} !== 4'b0010) begin
         errs++;
         $display("FAIL reset_ctrl: got req/we/stall/err=%b%b%b%b need 0010",
                  mif.mem_req, mif.mem_we, stall, bus_err);
      end
      vec++;
      if ({instr, r_data_mem} !== 64'h0) begin
         errs++;
         $display("FAIL reset_regs: got instr=%h rdata=%h need 0/0", instr, r_data_mem);
      end
      spur = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      vec++;
      if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h0) begin
         errs++;
         $display("FAIL reset_release: got req=%b addr=%h need 1/00000000", mif.mem_req, mif.mem_addr);
      end
   endtask

   task automatic test_zero_wait;
      run_instr(32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0);
      run_instr(32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 0);
   endtask

   task automatic test_load_wait;
      run_instr(32'h8, 1'b1, 1'b0, 32'h200, 32'h0, 2);
   endtask

   task automatic test_store;
      run_instr(32'hC, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 2);
      vec++;
      if (last_waddr !== 32'h100 || last_wdata !== 32'hDEADBEEF) begin
         errs++;
         $display("FAIL store_log: got %h/%h need 00000100/deadbeef", last_waddr, last_wdata);
      end
      run_instr(32'h10, 1'b1, 1'b1, 32'h104, 32'h0BADCAFE, 1);
      vec++;
      if (last_waddr !== 32'h104 || last_wdata !== 32'h0BADCAFE) begin
         errs++;
         $display("FAIL rw_as_write: got %h/%h need 00000104/0badcafe", last_waddr, last_wdata);
      end
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 6; i++) begin
         int unsigned kind;
         kind = $urandom_range(0, 2);
         run_instr(32'h40 + 32'(i) * 4, kind == 1, kind == 2,
                   32'h400 + 32'($urandom_range(0, 255)) * 4, $urandom, $urandom_range(0, 3));
      end
   endtask

   task automatic test_spurious_ack;
      logic [31:0] pi;
      logic [31:0] pr;
      run_instr(32'h80, 1'b1, 1'b0, 32'h480, 32'h0, 0);
      pi = instr;
      pr = r_data_mem;
      pc = 32'h84; Mem_read = 1'b0;
      spur = 1'b1;
      @(posedge clk);
      #1 spur = 1'b0;
      vec++;
      if (instr !== mem_val(32'h80) || r_data_mem !== mem_val(32'h480)) begin
         errs++;
         $display("FAIL spurious_regs: got %h/%h need %h/%h", instr, r_data_mem,
                  mem_val(32'h80), mem_val(32'h480));
      end
      vec++;
      if (stall !== 1'b1 || mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h84) begin
         errs++;
         $display("FAIL spurious_state: got stall=%b req=%b addr=%h need 1/1/00000084",
                  stall, mif.mem_req, mif.mem_addr);
      end
      if (pi !== instr) $display("note: instr moved from %h", pi);
      if (pr !== r_data_mem) $display("note: rdata moved from %h", pr);
      run_instr(32'h84, 1'b0, 1'b0, 32'h0, 32'h0, 0);
   endtask

   task automatic test_reset_mid_access;
      int k;
      pc = 32'h90; Mem_read = 1'b1; Mem_write = 1'b0; a_data_mem = 32'h300; lat = 5;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(mif.mem_req === 1'b1 && mif.mem_addr === 32'h300) && k < 40);
      vec++;
      if (k >= 40) begin
         errs++;
         $display("FAIL mid_reach_exec: got no data request need request at 00000300");
      end
      reset = 1'b0;
      #1;
      vec++;
      if ({mif.mem_req, mif.mem_we, stall, bus_err} !== 4'b0010 || instr !== 32'h0 || r_data_mem !== 32'h0) begin
         errs++;
         $display("FAIL mid_reset: got req/we/stall/err=%b%b%b%b instr=%h rdata=%h need 0010/0/0",
                  mif.mem_req, mif.mem_we, stall, bus_err, instr, r_data_mem);
      end
      spur = 1'b1;
      @(negedge clk);
      spur = 1'b0;
      vec++;
      if (instr !== 32'h0 || r_data_mem !== 32'h0 || mif.mem_req !== 1'b0) begin
         errs++;
         $display("FAIL ack_in_reset: got instr=%h rdata=%h req=%b need 0/0/0", instr, r_data_mem, mif.mem_req);
      end
      shadow_rdata = 32'h0;
      Mem_read = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      run_instr(32'h90, 1'b0, 1'b0, 32'h0, 32'h0, 0);
   endtask

   task automatic test_timeout;
`ifdef MEM_ARB_TIMEOUT_EN
      int k;
      logic [31:0] ei;
      pc = 32'hA0; Mem_read = 1'b0; Mem_write = 1'b0; lat = 100000;
      q_instr.push_back(32'h0000_0013);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (stall !== 1'b0 && k < 64);
      vec++;
      if (k != 17) begin
         errs++;
         $display("FAIL timeout_cycles: got %0d need 17", k);
      end
      ei = q_instr.pop_front();
      vec++;
      if (instr !== ei || bus_err !== 1'b1) begin
         errs++;
         $display("FAIL timeout_abort: got instr=%h err=%b need %h/1", instr, bus_err, ei);
      end
      run_instr(32'hA4, 1'b0, 1'b0, 32'h0, 32'h0, 0);
      vec++;
      if (bus_err !== 1'b1) begin
         errs++;
         $display("FAIL bus_err_sticky: got %b need 1", bus_err);
      end
`else
      run_instr(32'hA0, 1'b0, 1'b0, 32'h0, 32'h0, 20);
      vec++;
      if (bus_err !== 1'b0) begin
         errs++;
         $display("FAIL bus_err_tied: got %b need 0", bus_err);
      end
`endif
   endtask

   initial begin
      vec = 0;
      errs = 0;
      wait_cnt = 0;
      spur = 1'b0;
      test_reset;
      test_zero_wait;
      test_load_wait;
      test_store;
      test_back_to_back;
      test_spurious_ack;
      test_reset_mid_access;
      test_timeout;
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
